mc_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle MIPS processor.
- Executes the same MIPS subset (add, sub, and, or, slt, lw, sw, beq, addi, j), plus halt, through a control FSM.
- Uses one shared instruction/data memory port with a req/ready handshake, so memory of any latency can stall the core.
- Sits between the testbench/SoC memory model and the debug outputs.

---
 rtl/mc_core_pkg.sv | 46 ++++
 rtl/mc_core_alu.sv | 27 ++
 rtl/mc_core.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mc_core.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_core_pkg.sv
// Shared types and constants for the mc_core multi-cycle MIPS core:
// FSM state encoding, opcode/funct constants, ALU operation select.
package mc_core_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_HALT   = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_core_alu.sv
// Combinational 32-bit ALU for mc_core; shared by the branch-target,
// execute, address and branch-compare steps.
module mc_core_alu
  import mc_core_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
      default: y = a + b;
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/mc_core.sv
// Multi-cycle MIPS-subset core with one shared req/ready memory port.
// Optional performance counters (instret, cycles) under `MC_CORE_PERF_EN.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic              CLK,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              err,
  output logic [31:0]       dbg_pc,
  output logic [3:0]        dbg_state
`ifdef MC_CORE_PERF_EN
  ,
  output logic [31:0]       instret,
  output logic [31:0]       cycles
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] mdr_q, mdr_d;
  logic        err_q, err_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_zero;

  logic        req_state;
  logic        we_state;
  logic [31:0] addr_full;
  logic        funct_ok;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] rs_val, rt_val;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = sext16(ir_q[15:0]);

  assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  // Operand steering for the single shared ALU, decided by state alone.
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = ALU_ADD;
    case (state_q)
      S_DECODE: begin
        alu_a = pc_q;
        alu_b = {imm_sext[29:0], 2'b00};
      end
      S_EXEC_R: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_EXEC_I, S_ADDR: alu_b = imm_sext;
      S_BRANCH:         alu_op = ALU_SUB;
      default: ;
    endcase
  end

  mc_core_alu u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    err_d     = err_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;
    req_state = 1'b0;
    we_state  = 1'b0;
    addr_full = pc_q;

    case (state_q)
      S_FETCH: begin
        req_state = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = rs_val;
        b_d       = rt_val;
        alu_out_d = alu_y;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            if (opcode != HALT_OP) err_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        if (funct_ok) begin
          alu_out_d = alu_y;
          state_d   = S_WB_R;
        end else begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB_R: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_out_d = alu_y;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDR: begin
        alu_out_d = alu_y;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        req_state = 1'b1;
        addr_full = alu_out_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        req_state = 1'b1;
        we_state  = 1'b1;
        addr_full = alu_out_q;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        if (alu_zero) pc_d = alu_out_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Gating with rst makes the request vanish the instant reset asserts.
  assign mem_req   = req_state & rst;
  assign mem_we    = we_state & rst;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign halted    = (state_q == S_HALT);
  assign err       = err_q;
  assign dbg_pc    = pc_q;
  assign dbg_state = state_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
      mdr_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (rf_we && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
  end

`ifdef MC_CORE_PERF_EN
  logic [31:0] instret_q, instret_d;
  logic [31:0] cycles_q, cycles_d;
  logic        completing;

  assign completing = (state_q == S_WB_R)   || (state_q == S_WB_I) ||
                      (state_q == S_WB_MEM) || (state_q == S_MEM_WR) ||
                      (state_q == S_BRANCH) || (state_q == S_JUMP);

  always_comb begin
    cycles_d  = (state_q == S_HALT) ? cycles_q : cycles_q + 32'd1;
    instret_d = instret_q;
    if (completing && (state_d == S_FETCH)) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      instret_q <= 32'd0;
      cycles_q  <= 32'd0;
    end else begin
      instret_q <= instret_d;
      cycles_q  <= cycles_d;
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_mc_core.sv
// Scoreboard bench for mc_core: directed programs push their expected bus
// trace; a monitor compares every accepted memory access against it.
module tb_mc_core;

  logic        CLK;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halted;
  logic        err;
  logic [31:0] dbg_pc;
  logic [3:0]  dbg_state;
`ifdef MC_CORE_PERF_EN
  logic [31:0] instret;
  logic [31:0] cycles;
`endif

  mc_core dut (
    .CLK       (CLK),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .err       (err),
    .dbg_pc    (dbg_pc),
    .dbg_state (dbg_state)
`ifdef MC_CORE_PERF_EN
    ,
    .instret   (instret),
    .cycles    (cycles)
`endif
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [1024];
  bit          rand_waits;
  bit          stall_en;
  logic [31:0] stall_addr;
  bit          busy;
  int          wait_left;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] iw(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rw(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]] = word;
  endtask

  task automatic expRd(input logic [31:0] addr);
    txn_t t;
    t.we = 1'b0; t.addr = addr; t.data = 32'd0;
    exp_q.push_back(t);
  endtask

  task automatic expWr(input logic [31:0] addr, input logic [31:0] data);
    txn_t t;
    t.we = 1'b1; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  // Memory model: zero or random wait states, optional endless stall on one address.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    busy      = 1'b0;
    wait_left = 0;
    forever begin
      @(negedge CLK);
      if (!rst) begin
        busy      = 1'b0;
        mem_ready = 1'b0;
      end else begin
        if (mem_ready) begin
          busy      = 1'b0;
          mem_ready = 1'b0;
        end
        if (busy) begin
          checkOutput("hold_req",   {31'd0, mem_req}, 32'd1);
          checkOutput("hold_we",    {31'd0, mem_we}, {31'd0, lat_we});
          checkOutput("hold_addr",  mem_addr, lat_addr);
          checkOutput("hold_wdata", mem_wdata, lat_wdata);
        end else if (mem_req) begin
          busy      = 1'b1;
          wait_left = rand_waits ? int'($urandom_range(0, 3)) : 0;
          lat_we    = mem_we;
          lat_addr  = mem_addr;
          lat_wdata = mem_wdata;
        end
        if (busy && !(stall_en && mem_addr == stall_addr)) begin
          if (wait_left == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr[11:2]];
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          end else begin
            wait_left--;
          end
        end
      end
    end
  end

  // Monitor: every accepted access must match the head of the expected trace.
  initial begin
    txn_t t;
    forever begin
      @(negedge CLK);
      #1;
      if (rst && mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_access: got addr %h we %0b expected no access", mem_addr, mem_we);
        end else begin
          t = exp_q.pop_front();
          checkOutput("bus_addr", mem_addr, t.addr);
          checkOutput("bus_we", {31'd0, mem_we}, {31'd0, t.we});
          if (t.we) checkOutput("bus_wdata", mem_wdata, t.data);
        end
      end
    end
  end

  task automatic loadProgA();
    put(32'h00, iw(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, iw(6'h08, 5'd0, 5'd2, 16'd7));
    put(32'h08, rw(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, HALT_W);
  endtask

  task automatic loadProgC(input bit taken);
    put(32'h00, iw(6'h08, 5'd0, 5'd1, 16'd3));
    put(32'h04, iw(6'h08, 5'd0, 5'd2, 16'd4));
    put(32'h08, iw(6'h08, 5'd0, 5'd6, 16'hFFFF));
    put(32'h0C, iw(6'h08, 5'd0, 5'd7, 16'd1));
    put(32'h10, iw(6'h04, 5'd1, taken ? 5'd1 : 5'd2, 16'd2));
    put(32'h14, iw(6'h08, 5'd0, 5'd5, 16'd9));
    put(32'h18, iw(6'h2B, 5'd0, 5'd5, 16'h0050));
    put(32'h1C, rw(5'd6, 5'd7, 5'd5, 6'h2A));
    put(32'h20, {6'h02, 26'h0000100});
    put(32'h24, HALT_W);
    put(32'h400, iw(6'h2B, 5'd0, 5'd5, 16'h0054));
    put(32'h404, HALT_W);
    expRd(32'h00); expRd(32'h04); expRd(32'h08); expRd(32'h0C); expRd(32'h10);
    if (!taken) begin
      expRd(32'h14); expRd(32'h18); expWr(32'h50, 32'd9);
    end
    expRd(32'h1C); expRd(32'h20); expRd(32'h400); expWr(32'h54, 32'd1); expRd(32'h404);
  endtask

  // Loads a program with its expected trace, checks reset state, releases reset.
  task automatic applyStimulus(input int prog, input bit waits);
    rst        = 1'b0;
    rand_waits = waits;
    stall_en   = 1'b0;
    stall_addr = 32'd0;
    exp_q.delete();
    foreach (mem[i]) mem[i] = 32'd0;
    case (prog)
      1: begin
        loadProgA();
        expRd(32'h00); expRd(32'h04); expRd(32'h08); expRd(32'h0C);
      end
      2: begin
        put(32'h00, iw(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h04, iw(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h08, rw(5'd1, 5'd2, 5'd3, 6'h20));
        put(32'h0C, iw(6'h2B, 5'd0, 5'd3, 16'h0040));
        put(32'h10, iw(6'h23, 5'd0, 5'd4, 16'h0040));
        put(32'h14, iw(6'h2B, 5'd0, 5'd4, 16'h0044));
        put(32'h18, rw(5'd4, 5'd1, 5'd5, 6'h22));
        put(32'h1C, iw(6'h2B, 5'd0, 5'd5, 16'h0048));
        put(32'h20, rw(5'd3, 5'd2, 5'd6, 6'h24));
        put(32'h24, rw(5'd6, 5'd1, 5'd7, 6'h25));
        put(32'h28, iw(6'h2B, 5'd0, 5'd7, 16'h004C));
        put(32'h2C, HALT_W);
        expRd(32'h00); expRd(32'h04); expRd(32'h08); expRd(32'h0C); expWr(32'h40, 32'd12);
        expRd(32'h10); expRd(32'h40); expRd(32'h14); expWr(32'h44, 32'd12);
        expRd(32'h18); expRd(32'h1C); expWr(32'h48, 32'd7);
        expRd(32'h20); expRd(32'h24); expRd(32'h28); expWr(32'h4C, 32'd5); expRd(32'h2C);
      end
      3: loadProgC(1'b1);
      4: loadProgC(1'b0);
      5: begin
        put(32'h00, 32'hF800_0000);
        expRd(32'h00);
      end
      6: begin
        put(32'h00, rw(5'd0, 5'd0, 5'd3, 6'h3F));
        expRd(32'h00);
      end
      default: begin
        loadProgA();
        stall_en   = 1'b1;
        stall_addr = 32'h08;
        expRd(32'h00); expRd(32'h04);
      end
    endcase
    repeat (2) @(negedge CLK);
    checkOutput("rst_req",    {31'd0, mem_req}, 32'd0);
    checkOutput("rst_we",     {31'd0, mem_we}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_err",    {31'd0, err}, 32'd0);
    checkOutput("rst_pc",     dbg_pc, 32'd0);
    checkOutput("rst_state",  {28'd0, dbg_state}, 32'd0);
    @(posedge CLK);
    #1 rst = 1'b1;
  endtask

  task automatic runUntilHalt(output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge CLK);
      if (halted) break;
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("[TB] FAIL halt_timeout: got halted=0 after %0d cycles expected halted=1", n);
    end
  endtask

  task automatic finishRun(input string name, input bit exp_err);
    int seen;
    checkOutput({name, "_halted"}, {31'd0, halted}, 32'd1);
    checkOutput({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    checkOutput({name, "_pending"}, exp_q.size(), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (mem_req) seen++;
    end
    checkOutput({name, "_req_after_halt"}, seen, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0;

    applyStimulus(1, 1'b0);
    runUntilHalt(n);
    checkOutput("progA_cycles", n, 32'd14);
`ifdef MC_CORE_PERF_EN
    checkOutput("perf_instret", instret, 32'd3);
    checkOutput("perf_cycles", cycles, 32'd14);
`endif
    finishRun("progA", 1'b0);

    applyStimulus(2, 1'b1);
    runUntilHalt(n);
    finishRun("memops", 1'b0);

    applyStimulus(3, 1'b0);
    runUntilHalt(n);
    finishRun("beq_taken", 1'b0);

    applyStimulus(4, 1'b1);
    runUntilHalt(n);
    finishRun("beq_not_taken", 1'b0);

    applyStimulus(5, 1'b0);
    runUntilHalt(n);
    finishRun("bad_opcode", 1'b1);

    applyStimulus(6, 1'b0);
    runUntilHalt(n);
    finishRun("bad_funct", 1'b1);

    applyStimulus(7, 1'b0);
    n = 0;
    while (!(mem_req && mem_addr == 32'h08) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("stall_reached", {31'd0, (n < 100)}, 32'd1);
    repeat (3) @(negedge CLK);
    checkOutput("stall_pc", dbg_pc, 32'h08);
    checkOutput("stall_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_req", {31'd0, mem_req}, 32'd0);
    checkOutput("abort_pc", dbg_pc, 32'd0);
    checkOutput("abort_state", {28'd0, dbg_state}, 32'd0);
    checkOutput("abort_pending", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
